// File: rtl/serial_compare_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Holds the controller state encoding, the one-hot result codes and the index-width helper.
package serial_compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // One-hot result codes: bit 0 = equal, bit 1 = greater, bit 2 = less.
  localparam int          RES_W  = 3;
  localparam logic [2:0]  RES_EQ = 3'b001;
  localparam logic [2:0]  RES_GT = 3'b010;
  localparam logic [2:0]  RES_LT = 3'b100;

  // Index width for a WIDTH-bit operand; only ever evaluated at elaboration.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result++;
        rem = rem >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational 1-bit compare cell shared across all bit positions by the controller.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = x & ~y;
  assign lt = ~x & y;
  assign eq = ~(x ^ y);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller: walks one compare cell MSB-first over latched operands.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan on the first differing bit.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             esit,
  output logic             buyuk,
  output logic             kucuk
);

  import serial_compare_pkg::*;

  localparam int               IDX_W   = clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               decided_q;
  logic [RES_W-1:0]   pend_q;
  logic [RES_W-1:0]   res_q;
  logic               busy_q;
  logic               done_q;

  logic               cell_gt;
  logic               cell_lt;
  logic               cell_eq;
  logic [RES_W-1:0]   bit_res_d;
  logic [RES_W-1:0]   final_res_d;
  logic               hit_d;
  logic               last_bit_d;
  logic               finish_d;

  cmp_bit_cell u_cell (
    .x  (a_q[idx_q]),
    .y  (b_q[idx_q]),
    .gt (cell_gt),
    .lt (cell_lt),
    .eq (cell_eq)
  );

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    bit_res_d = RES_EQ;
    if (cell_gt) begin
      bit_res_d = RES_GT;
    end else if (cell_lt) begin
      bit_res_d = RES_LT;
    end
    hit_d       = !decided_q && !cell_eq;
    final_res_d = decided_q ? pend_q : bit_res_d;
    last_bit_d  = (idx_q == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish_d    = hit_d || last_bit_d;
`else
    finish_d    = last_bit_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, so the cell input is defined straight after reset.
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      pend_q    <= RES_EQ;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            idx_q     <= IDX_MSB;
            decided_q <= 1'b0;
            pend_q    <= RES_EQ;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end else begin
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          // Only the first differing bit from the MSB may set the result.
          if (hit_d) begin
            pend_q    <= bit_res_d;
            decided_q <= 1'b1;
          end
          if (finish_d) begin
            res_q   <= final_res_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q - IDX_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign esit  = res_q[0];
  assign buyuk = res_q[1];
  assign kucuk = res_q[2];

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed self-checking bench for serial_compare_ctrl (WIDTH=8), for either early-exit setting.
module tb_serial_compare_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic       busy;
  logic       done;
  logic       esit;
  logic       buyuk;
  logic       kucuk;

  int total = 0;
  int bad   = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .esit  (esit),
    .buyuk (buyuk),
    .kucuk (kucuk)
  );

  always #5 clk = ~clk;

  // Scan cycles for a first difference at MSB offset m (equal operands: pass 7).
  function automatic int scan_len(input int m);
    return EARLY ? (m + 1) : 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic e, input logic g, input logic l);
    check({tag, "_esit"},  {31'd0, esit},  {31'd0, e});
    check({tag, "_buyuk"}, {31'd0, buyuk}, {31'd0, g});
    check({tag, "_kucuk"}, {31'd0, kucuk}, {31'd0, l});
  endtask

  // Called #1 after an edge with the block in IDLE/DONE; returns #1 after E0 (first SCAN cycle).
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Entered at cycle n0 after E0; done must rise in cycle exp_scan+1, bounded at 40 cycles.
  task automatic wait_done(input string tag, input int n0, input int exp_scan);
    int n;
    n = n0;
    check({tag, "_busy_scan"}, {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_scan + 1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (busy) busys++;
    end
    check({tag, "_extra_done"}, dones, 0);
    check({tag, "_idle_busy"},  busys, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_res("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Equal operands: full scan in both settings.
    launch(8'hA5, 8'hA5);
    wait_done("eq", 1, scan_len(7));
    check_res("eq", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("eq_done_pulse", {31'd0, done}, 32'd0);
    check_res("eq_hold", 1'b1, 1'b0, 1'b0);

    // MSB decides.
    launch(8'h80, 8'h7F);
    wait_done("msb", 1, scan_len(0));
    check_res("msb", 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // LSB decides.
    launch(8'h12, 8'h13);
    wait_done("lsb", 1, scan_len(7));
    check_res("lsb", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Start during SCAN is ignored.
    launch(8'h40, 8'h00);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", 2, scan_len(1));
    check_res("ign", 1'b0, 1'b1, 1'b0);
    quiet("ign", 12);

    // Reset in the 3rd SCAN cycle aborts everything.
    launch(8'h01, 8'h02);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check_res("abort", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet("abort", 12);
    check_res("abort_after", 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held across DONE with a new pair.
    launch(8'h80, 8'h7F);
    wait_done("b2b1", 1, scan_len(0));
    check_res("b2b1", 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    check("b2b_busy_again", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check_res("b2b_hold", 1'b0, 1'b1, 1'b0);
    wait_done("b2b2", 1, scan_len(2));
    check_res("b2b2", 1'b0, 1'b0, 1'b1);
    quiet("b2b", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
